alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit integer ALU for the CPU datapath; computes one of ten arithmetic/logic/shift/compare operations on two operands and produces a result plus NZCV condition flags.
- Result and flags are registered, giving 1-cycle latency. Outputs feed the writeback mux and the branch/condition unit.

Parameters:
- WIDTH, 32, operand/result width; the flag semantics below assume WIDTH ≥ 2, shifts use the low log2(WIDTH) bits of b.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A (two's complement or unsigned, per op).
- b  input  WIDTH  operand B / shift amount.
- op  input  4  operation select (encoding below).
- res  output  WIDTH  registered result.
- flags  output  4  registered flags {N,Z,C,V}: bit3 N, bit2 Z, bit1 C, bit0 V.

Behaviour:
- Reset: rst_n low immediately forces res=0, flags=4'b0000, independent of clk. Released synchronously in effect; first capture at the next rising edge with rst_n high.
- Latency: a/b/op sampled at each rising edge; res/flags valid from that edge until the next. No enable, no handshake; a new operation every cycle.
- op encoding:
  - 0 ADD: a+b.
  - 1 SUB: a+~b+1.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL: a<<b[4:0].
  - 6 SRL: logical right shift.
  - 7 SRA: arithmetic right shift.
  - 8 SLT: signed a<b gives 1, else 0.
  - 9 SLTU: unsigned compare.
  - 10-15 reserved: res=0.
- Flags for every op:
  - N = res[WIDTH-1].
  - Z = (res==0).
- C, V for ADD/SUB only:
  - C = carry-out of bit WIDTH-1 of the adder. For SUB, C=1 means no borrow (a ≥ b unsigned).
  - V = signed overflow, i.e. both adder inputs have the same sign and the sum sign differs.
- C=V=0 for all other ops, including reserved. Reserved ops therefore give flags=4'b0100.
- Shift amounts 0..31 are legal. Amount 0 passes a through. Upper bits of b are ignored for shifts.
- Width rules: all arithmetic is modulo 2^WIDTH. There are no exceptions or traps.

Decomposition:
- Package alu_pkg:
  - enum alu_op_t for the op codes above (ALU_ADD..ALU_SLTU).
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_adder: WIDTH-bit adder with cin, outputs sum, cout, ovf. It is shared by ADD, SUB, SLT and SLTU, with b inverted and cin=1 for the subtract/compare ops.
- The top level holds the op mux, flag generation and the output register.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> res=0, flags=0000 immediately. Release, then ADD 2+3 -> next edge res=5, flags=0000.
- ADD corners, each checked one cycle after sampling:
  - 0+0 -> res 0, flags 0100.
  - -32+-7 -> res -39, flags 1010.
  - 8+-7 -> res 1, flags 0010.
  - -32+33 -> res 1, flags 0010.
  - 0x7ffffff5+11 -> res 0x80000000, flags 1001.
  - 11+-11 -> res 0, flags 0110.
  - 0xffffffff+5 -> res 4, flags 0010.
  - 20+-25 -> res -5, flags 1000.
- SUB:
  - 5-5 -> res 0, flags 0110.
  - 3-5 -> res -2, flags 1000.
  - 0x80000000-1 -> res 0x7fffffff, flags 0011.
- Logic/shift:
  - AND 0xf0f0f0f0 & 0x0ff00ff0 -> 0x00f000f0, flags 0000.
  - XOR x^x -> 0, flags 0100.
  - SLL 1<<31 -> 0x80000000, flags 1000.
  - SRA 0x80000000>>4 -> 0xf8000000.
  - SRL 0x80000000>>4 -> 0x08000000.
  - SLL with b=0x21 -> shifts by 1.
- Compare:
  - SLT -1<1 -> res 1.
  - SLTU 0xffffffff<1 -> res 0, flags 0100.
  - SLT 1<-1 -> res 0.
- Reserved and back-to-back:
  - op=12 -> res 0, flags 0100.
  - Change op every cycle -> each result appears exactly one cycle after its inputs.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes and flag bit positions shared by the ALU and its users
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/op inputs and registered result/flags of the ALU
interface alu_if #(parameter int WIDTH = 32);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic [WIDTH-1:0] res;
  logic [3:0]       flags;

  modport master (output a, output b, output op, input res, input flags);
  modport slave  (input a, input b, input op, output res, output flags);

endinterface

// File: rtl/alu_adder.sv
// rtl/alu_adder.sv - WIDTH-bit adder with carry-in, carry-out and signed overflow
module alu_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  logic [WIDTH:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
  assign sum_o  = full[WIDTH-1:0];
  assign cout_o = full[WIDTH];
  // Overflow: like-signed inputs producing a sum of the other sign.
  assign ovf_o  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered 32-bit ALU: op mux, NZCV flag generation, output register
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  logic             sub;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_d, res_q;
  logic [3:0]       flags_d, flags_q;
  logic             c_d, v_d;

  // Subtract and both compares reuse the adder as a + ~b + 1.
  assign sub   = (bus.op == ALU_SUB) || (bus.op == ALU_SLT) || (bus.op == ALU_SLTU);
  assign add_b = sub ? ~bus.b : bus.b;
  assign shamt = bus.b[SHW-1:0];

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a_i    (bus.a),
    .b_i    (add_b),
    .cin_i  (sub),
    .sum_o  (sum),
    .cout_o (cout),
    .ovf_o  (ovf)
  );

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (alu_op_t'(bus.op))
      ALU_ADD, ALU_SUB: begin
        res_d = sum;
        c_d   = cout;
        v_d   = ovf;
      end
      ALU_AND:  res_d = bus.a & bus.b;
      ALU_OR:   res_d = bus.a | bus.b;
      ALU_XOR:  res_d = bus.a ^ bus.b;
      ALU_SLL:  res_d = bus.a << shamt;
      ALU_SRL:  res_d = bus.a >> shamt;
      ALU_SRA:  res_d = $signed(bus.a) >>> shamt;
      // Signed less-than is the true sign of a-b, corrected for overflow.
      ALU_SLT:  res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      ALU_SLTU: res_d = {{(WIDTH-1){1'b0}}, ~cout};
      default:  res_d = '0;
    endcase
  end

  always_comb begin
    flags_d         = 4'b0000;
    flags_d[FLAG_N] = res_d[WIDTH-1];
    flags_d[FLAG_Z] = (res_d == '0);
    flags_d[FLAG_C] = c_d;
    flags_d[FLAG_V] = v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      flags_q <= 4'b0000;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign bus.res   = res_q;
  assign bus.flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed-vector self-checking bench for the alu
module tb_alu;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if (bus.res !== 32'h0 || bus.flags !== 4'b0000)
      $display("FAIL reset_initial: res=%h flags=%b expected res=00000000 flags=0000", bus.res, bus.flags);
    else n_pass++;
    step(ALU_ADD, 32'd2, 32'd3);
    n_total++;
    if (bus.res !== 32'h0 || bus.flags !== 4'b0000)
      $display("FAIL reset_held: res=%h flags=%b expected res=00000000 flags=0000", bus.res, bus.flags);
    else n_pass++;
    rst_n = 1'b1;
    step(ALU_ADD, 32'd2, 32'd3);
    n_total++;
    if (bus.res !== 32'd5 || bus.flags !== 4'b0000)
      $display("FAIL reset_release_add: res=%h flags=%b expected res=00000005 flags=0000", bus.res, bus.flags);
    else n_pass++;
    step(ALU_ADD, 32'hffffffff, 32'hffffffff);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.res !== 32'h0 || bus.flags !== 4'b0000)
      $display("FAIL reset_async: res=%h flags=%b expected res=00000000 flags=0000", bus.res, bus.flags);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step(ALU_ADD, 32'd2, 32'd3);
    n_total++;
    if (bus.res !== 32'd5 || bus.flags !== 4'b0000)
      $display("FAIL reset_rerelease_add: res=%h flags=%b expected res=00000005 flags=0000", bus.res, bus.flags);
    else n_pass++;
  endtask

  task automatic test_add();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vr [8];
    logic [3:0]  vf [8];
    va = '{32'd0, 32'hffffffe0, 32'd8,       32'hffffffe0, 32'h7ffffff5, 32'd11,      32'hffffffff, 32'd20};
    vb = '{32'd0, 32'hfffffff9, 32'hfffffff9, 32'd33,      32'd11,       32'hfffffff5, 32'd5,       32'hffffffe7};
    vr = '{32'd0, 32'hffffffd9, 32'd1,       32'd1,       32'h80000000, 32'd0,       32'd4,       32'hfffffffb};
    vf = '{4'b0100, 4'b1010, 4'b0010, 4'b0010, 4'b1001, 4'b0110, 4'b0010, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      step(ALU_ADD, va[i], vb[i]);
      n_total++;
      if (bus.res !== vr[i] || bus.flags !== vf[i])
        $display("FAIL add[%0d]: res=%h flags=%b expected res=%h flags=%b", i, bus.res, bus.flags, vr[i], vf[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sub();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] vr [3];
    logic [3:0]  vf [3];
    va = '{32'd5, 32'd3,       32'h80000000};
    vb = '{32'd5, 32'd5,       32'd1};
    vr = '{32'd0, 32'hfffffffe, 32'h7fffffff};
    vf = '{4'b0110, 4'b1000, 4'b0011};
    for (int i = 0; i < 3; i++) begin
      step(ALU_SUB, va[i], vb[i]);
      n_total++;
      if (bus.res !== vr[i] || bus.flags !== vf[i])
        $display("FAIL sub[%0d]: res=%h flags=%b expected res=%h flags=%b", i, bus.res, bus.flags, vr[i], vf[i]);
      else n_pass++;
    end
  endtask

  task automatic test_logic_shift();
    logic [3:0]  vo [8];
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vr [8];
    logic [3:0]  vf [8];
    vo = '{ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRA, ALU_SRL, ALU_SLL, ALU_SRL};
    va = '{32'hf0f0f0f0, 32'h000000a0, 32'h5a5a1234, 32'd1, 32'h80000000, 32'h80000000, 32'd3, 32'h12345678};
    vb = '{32'h0ff00ff0, 32'h0000000a, 32'h5a5a1234, 32'd31, 32'd4, 32'd4, 32'h21, 32'd0};
    vr = '{32'h00f000f0, 32'h000000aa, 32'h0,        32'h80000000, 32'hf8000000, 32'h08000000, 32'd6, 32'h12345678};
    vf = '{4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      step(vo[i], va[i], vb[i]);
      n_total++;
      if (bus.res !== vr[i] || bus.flags !== vf[i])
        $display("FAIL logic_shift[%0d]: res=%h flags=%b expected res=%h flags=%b", i, bus.res, bus.flags, vr[i], vf[i]);
      else n_pass++;
    end
  endtask

  task automatic test_compare();
    logic [3:0]  vo [5];
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] vr [5];
    logic [3:0]  vf [5];
    vo = '{ALU_SLT, ALU_SLTU, ALU_SLT, ALU_SLTU, ALU_SLT};
    va = '{32'hffffffff, 32'hffffffff, 32'd1, 32'd1, 32'h80000000};
    vb = '{32'd1, 32'd1, 32'hffffffff, 32'hffffffff, 32'd1};
    vr = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd1};
    vf = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      step(vo[i], va[i], vb[i]);
      n_total++;
      if (bus.res !== vr[i] || bus.flags !== vf[i])
        $display("FAIL compare[%0d]: res=%h flags=%b expected res=%h flags=%b", i, bus.res, bus.flags, vr[i], vf[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reserved();
    logic [3:0] vo [3];
    vo = '{4'd10, 4'd12, 4'd15};
    for (int i = 0; i < 3; i++) begin
      step(vo[i], 32'hffffffff, 32'd1);
      n_total++;
      if (bus.res !== 32'h0 || bus.flags !== 4'b0100)
        $display("FAIL reserved[op=%0d]: res=%h flags=%b expected res=00000000 flags=0100", vo[i], bus.res, bus.flags);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  vo [7];
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] vr [7];
    logic [3:0]  vf [7];
    vo = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLT, ALU_SRA, 4'd11, ALU_ADD};
    va = '{32'd1, 32'd10, 32'hff, 32'd2, 32'hfffffff0, 32'd9, 32'h7fffffff};
    vb = '{32'd2, 32'd3,  32'h0f, 32'd5, 32'd2,        32'd9, 32'd1};
    vr = '{32'd3, 32'd7,  32'hf0, 32'd1, 32'hfffffffc, 32'd0, 32'h80000000};
    vf = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b1001};
    for (int i = 0; i < 7; i++) begin
      bus.op = vo[i];
      bus.a  = va[i];
      bus.b  = vb[i];
      if (i > 0) begin
        #3;
        n_total++;
        if (bus.res !== vr[i-1] || bus.flags !== vf[i-1])
          $display("FAIL b2b_hold[%0d]: res=%h flags=%b expected res=%h flags=%b", i, bus.res, bus.flags, vr[i-1], vf[i-1]);
        else n_pass++;
      end
      @(posedge clk);
      #1;
      n_total++;
      if (bus.res !== vr[i] || bus.flags !== vf[i])
        $display("FAIL b2b[%0d]: res=%h flags=%b expected res=%h flags=%b", i, bus.res, bus.flags, vr[i], vf[i]);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus.op  = 4'd0;
    bus.a   = 32'd0;
    bus.b   = 32'd0;
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_compare();
    test_reserved();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
